// File: rtl/tpu_load_sequencer.sv
// Purpose : sequences one matrix-multiply job. It takes host operand words, shifts them
//           LSB-first into the operand loader, pulses init, waits, then pulses done.
// Latency : all outputs are registered. done follows init by COMP_LAT cycles, and
//           load_en stays high for 1 + D_W*N*N + 1 cycles.
// Backpr. : wr_valid/wr_ready handshake. A one-word skid buffer sits behind the shift
//           register. If the buffer is empty at a word boundary, the block latches ERR.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    begin a job (sampled in IDLE only)
//   wr_valid/wr_ready        host word handshake
//   x_data, y_data           parallel operand words
//   load_en, data_in_x/y     serial load interface to the operand loader
//   init                     one-cycle launch pulse to the loader
//   busy, done, err          status: busy outside IDLE, done pulse, sticky underrun
//   cycle_cnt                busy-cycle counter (only when SEQ_CYCLE_CNT_EN is defined)
//
// Optional feature macro: SEQ_CYCLE_CNT_EN
module tpu_load_sequencer #(
  parameter int D_W      = 8,
  parameter int N        = 2,
  parameter int COMP_LAT = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [D_W-1:0] x_data,
  input  logic [D_W-1:0] y_data,
  output logic           load_en,
  output logic           data_in_x,
  output logic           data_in_y,
  output logic           init,
  output logic           busy,
  output logic           done,
  output logic           err
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]    cycle_cnt
`endif
);

  localparam int NW = N * N;
  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam int WW = $clog2(NW + 1);
  localparam int LW = $clog2(COMP_LAT + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRIME,
    ST_SHIFT,
    ST_TAIL,
    ST_FIRE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t         state, state_n;
  logic [BW-1:0]  bit_cnt, bit_cnt_n;
  logic [WW-1:0]  word_cnt, word_cnt_n;
  logic [WW-1:0]  acc_cnt, acc_cnt_n;    // words accepted in this job
  logic [LW-1:0]  lat_cnt, lat_cnt_n;
  logic [D_W-1:0] sh_x, sh_x_n, sh_y, sh_y_n;
  logic [D_W-1:0] buf_x, buf_x_n, buf_y, buf_y_n;
  logic           buf_vld, buf_vld_n;
  logic           hs;

  logic wr_ready_n, load_en_n, data_in_x_n, data_in_y_n;
  logic init_n, busy_n, done_n, err_n;

  assign hs = wr_valid && wr_ready;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    acc_cnt_n  = acc_cnt;
    lat_cnt_n  = lat_cnt;
    sh_x_n     = sh_x;
    sh_y_n     = sh_y;
    buf_x_n    = buf_x;
    buf_y_n    = buf_y;
    buf_vld_n  = buf_vld;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_FILL;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
          acc_cnt_n  = '0;
          buf_vld_n  = 1'b0;
        end
      end
      ST_FILL: begin
        if (hs) begin
          sh_x_n    = x_data;
          sh_y_n    = y_data;
          acc_cnt_n = acc_cnt + WW'(1);
          state_n   = ST_PRIME;
        end
      end
      ST_PRIME: state_n = ST_SHIFT;
      ST_SHIFT: begin
        // The boundary decision uses the buffer as it stands this cycle. A word
        // arriving on the very last bit is too late to be used.
        if (bit_cnt == BW'(D_W - 1)) begin
          if (word_cnt == WW'(NW - 1)) begin
            state_n = ST_TAIL;
          end else if (buf_vld) begin
            sh_x_n     = buf_x;
            sh_y_n     = buf_y;
            buf_vld_n  = 1'b0;
            bit_cnt_n  = '0;
            word_cnt_n = word_cnt + WW'(1);
          end else begin
            state_n = ST_ERR;
          end
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
        // A handshake always wins over the drain, so the new word lands in the buffer.
        if (hs) begin
          buf_x_n   = x_data;
          buf_y_n   = y_data;
          buf_vld_n = 1'b1;
          acc_cnt_n = acc_cnt + WW'(1);
        end
      end
      ST_TAIL: state_n = ST_FIRE;
      ST_FIRE: begin
        lat_cnt_n = LW'(1);
        state_n   = (COMP_LAT == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == LW'(COMP_LAT - 1)) state_n = ST_DONE;
        else                              lat_cnt_n = lat_cnt + LW'(1);
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_ERR;   // loader bit alignment is lost; only reset recovers
      default: state_n = ST_IDLE;
    endcase

    // Outputs are computed from the next-state values and then registered, so each
    // output reflects the state it is in during that cycle.
    load_en_n   = (state_n == ST_PRIME) || (state_n == ST_SHIFT) || (state_n == ST_TAIL);
    data_in_x_n = (state_n == ST_SHIFT) ? sh_x_n[bit_cnt_n] : 1'b0;
    data_in_y_n = (state_n == ST_SHIFT) ? sh_y_n[bit_cnt_n] : 1'b0;
    init_n      = (state_n == ST_FIRE);
    done_n      = (state_n == ST_DONE);
    busy_n      = (state_n != ST_IDLE);
    err_n       = (state_n == ST_ERR);
    wr_ready_n  = (state_n == ST_FILL) ||
                  ((state_n == ST_SHIFT) && !buf_vld_n && (acc_cnt_n < WW'(NW)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      acc_cnt   <= '0;
      lat_cnt   <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      buf_x     <= '0;
      buf_y     <= '0;
      buf_vld   <= 1'b0;
      wr_ready  <= 1'b0;
      load_en   <= 1'b0;
      data_in_x <= 1'b0;
      data_in_y <= 1'b0;
      init      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      word_cnt  <= word_cnt_n;
      acc_cnt   <= acc_cnt_n;
      lat_cnt   <= lat_cnt_n;
      sh_x      <= sh_x_n;
      sh_y      <= sh_y_n;
      buf_x     <= buf_x_n;
      buf_y     <= buf_y_n;
      buf_vld   <= buf_vld_n;
      wr_ready  <= wr_ready_n;
      load_en   <= load_en_n;
      data_in_x <= data_in_x_n;
      data_in_y <= data_in_y_n;
      init      <= init_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  // Cleared when a start is accepted; counts every non-IDLE cycle and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      cycle_cnt <= '0;
    end else if ((state != ST_IDLE) && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_load_sequencer.sv
// Purpose : directed and randomized jobs for tpu_load_sequencer, checked against
//           stream, timing and handshake expectations computed from operand words.
module tb_tpu_load_sequencer;

  localparam int D_W      = 8;
  localparam int N        = 2;
  localparam int NW       = N * N;
  localparam int COMP_LAT = 6;
  localparam int LOAD_LEN = 1 + D_W * NW + 1;
  localparam int MAXC     = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] x_data = 8'h00;
  logic [7:0] y_data = 8'h00;
  logic       load_en, data_in_x, data_in_y, init, busy, done, err;
`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpu_load_sequencer #(.D_W(D_W), .N(N), .COMP_LAT(COMP_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .x_data    (x_data),
    .y_data    (y_data),
    .load_en   (load_en),
    .data_in_x (data_in_x),
    .data_in_y (data_in_y),
    .init      (init),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  // Job description and per-cycle log.
  logic [7:0] xw [NW];
  logic [7:0] yw [NW];
  int         dly [NW];
  bit le_l[MAXC], dx_l[MAXC], dy_l[MAXC], in_l[MAXC], dn_l[MAXC];
  bit bz_l[MAXC], er_l[MAXC], rd_l[MAXC], hs_l[MAXC];
  int ncyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle-by-cycle host driver and logger. Outputs are sampled at the negedge, and
  // inputs change at the same negedge for the following posedge.
  task automatic run_job(input bit hold, input bit ign_start, input int abort_bits, input int maxc);
    int wi = 0, wait_cnt = dly[0], le_cnt = 0, init_c = -1, done_c = -1;
    bit hs_pend = 1'b0;
    ncyc = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      le_l[c] = load_en; dx_l[c] = data_in_x; dy_l[c] = data_in_y;
      in_l[c] = init; dn_l[c] = done; bz_l[c] = busy; er_l[c] = err;
      rd_l[c] = wr_ready; hs_l[c] = 1'b0;
      ncyc = c + 1;
      if (load_en) le_cnt++;
      if (init && init_c < 0) init_c = c;
      if (done && done_c < 0) done_c = c;
      if (abort_bits > 0 && le_cnt == abort_bits + 1) break;
      if (hs_pend) begin
        wi++;
        wait_cnt = (wi < NW) ? dly[wi] : 0;
      end
      if (wi < NW && wait_cnt == 0) begin
        wr_valid = 1'b1; x_data = xw[wi]; y_data = yw[wi];
      end else if (wi >= NW && hold) begin
        wr_valid = 1'b1; x_data = 8'($urandom); y_data = 8'($urandom);
      end else begin
        wr_valid = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
      end
      hs_l[c] = wr_valid && wr_ready;
      hs_pend = hs_l[c];
      start = (c == 0) || (ign_start && ((le_cnt == 6 && load_en) ||
                                         (init_c >= 0 && c == init_c + 2)));
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    wr_valid = 1'b0;
    start = 1'b0;
  endtask

  // Expected behaviour of a successful job, derived from the operand words.
  task automatic check_job(input string tag);
    int le_s = -1, le_len = 0, le_tot = 0, nin = 0, ndn = 0, in_c = -1, dn_c = -1;
    int nhs = 0, nerr = 0, rdy_viol = 0, nbusy = 0;
    logic [LOAD_LEN-1:0] ox, oy, ex, ey;
    for (int c = 0; c < ncyc; c++) begin
      if (le_l[c]) begin le_tot++; if (le_s < 0) le_s = c; end
      if (in_l[c]) begin nin++; if (in_c < 0) in_c = c; end
      if (dn_l[c]) begin ndn++; if (dn_c < 0) dn_c = c; end
      if (hs_l[c]) nhs++;
      if (er_l[c]) nerr++;
      if (bz_l[c]) nbusy++;
      if (c > 0 && hs_l[c-1] && rd_l[c]) rdy_viol++;
    end
    if (le_s < 0) le_s = 0;
    for (int c = le_s; c < ncyc && le_l[c]; c++) le_len++;
    for (int i = 0; i < LOAD_LEN; i++) begin
      ox[i] = (le_s + i < ncyc) ? dx_l[le_s + i] : 1'b0;
      oy[i] = (le_s + i < ncyc) ? dy_l[le_s + i] : 1'b0;
      if (i == 0 || i == LOAD_LEN - 1) begin
        ex[i] = 1'b0; ey[i] = 1'b0;
      end else begin
        ex[i] = xw[(i-1) / D_W][(i-1) % D_W];
        ey[i] = yw[(i-1) / D_W][(i-1) % D_W];
      end
    end
    chk({tag, ".load_len"}, le_len, LOAD_LEN);
    chk({tag, ".load_total"}, le_tot, LOAD_LEN);
    chk({tag, ".x_stream"}, ox, ex);
    chk({tag, ".y_stream"}, oy, ey);
    chk({tag, ".init_count"}, nin, 1);
    chk({tag, ".init_pos"}, in_c, le_s + LOAD_LEN);
    chk({tag, ".done_count"}, ndn, 1);
    chk({tag, ".done_pos"}, dn_c, in_c + COMP_LAT);
    chk({tag, ".busy_at_done"}, (dn_c >= 0) ? bz_l[dn_c] : 1'b0, 1);
    chk({tag, ".busy_after_done"}, (dn_c >= 0 && dn_c + 1 < ncyc) ? bz_l[dn_c+1] : 1'b1, 0);
    chk({tag, ".busy_idle2"}, (dn_c >= 0 && dn_c + 2 < ncyc) ? bz_l[dn_c+2] : 1'b1, 0);
    chk({tag, ".err_cycles"}, nerr, 0);
    chk({tag, ".handshakes"}, nhs, NW);
    chk({tag, ".ready_when_full"}, rdy_viol, 0);
`ifdef SEQ_CYCLE_CNT_EN
    chk({tag, ".cycle_cnt"}, cycle_cnt, nbusy);
`endif
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    wr_valid = 1'b0;
    start = 1'b0;
    #1;
    chk({tag, ".load_en"}, load_en, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".wr_ready"}, wr_ready, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".init_done"}, {init, done, data_in_x, data_in_y}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_basic();
    xw[0] = 8'h01; xw[1] = 8'h80; xw[2] = 8'hFF; xw[3] = 8'h5A;
    yw[0] = 8'h02; yw[1] = 8'h04; yw[2] = 8'h08; yw[3] = 8'h10;
    for (int k = 0; k < NW; k++) dly[k] = 0;
  endtask

  initial begin
    int le_s, le_len, errs_after, rdy_err, nin, ndn;

    // Reset state.
    #1;
    reset_check("reset");

    // Basic job with back-to-back host words.
    set_basic();
    run_job(1'b0, 1'b0, 0, 120);
    check_job("basic");

    // Randomized data and host delays (short enough that the buffer never underruns).
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < NW; k++) begin
        xw[k] = 8'($urandom);
        yw[k] = 8'($urandom);
        dly[k] = (k == 0) ? $urandom_range(0, 4) : $urandom_range(0, 3);
      end
      run_job(1'b0, 1'b0, 0, 140);
      check_job($sformatf("rand%0d", j));
    end

    // Host holds wr_valid continuously: only four words may be taken.
    set_basic();
    run_job(1'b1, 1'b0, 0, 120);
    check_job("hold_valid");

    // Starts issued during SHIFT and WAIT must be ignored.
    for (int k = 0; k < NW; k++) begin xw[k] = 8'($urandom); yw[k] = 8'($urandom); end
    run_job(1'b0, 1'b1, 0, 120);
    check_job("ign_start");

    // Reset after 13 bits, then a clean job.
    set_basic();
    run_job(1'b0, 1'b0, 13, 120);
    reset_check("reset_mid");
    run_job(1'b0, 1'b0, 0, 120);
    check_job("after_reset");

    // Underrun: second word arrives after the first word boundary.
    set_basic();
    dly[1] = 12;
    run_job(1'b0, 1'b0, 0, 60);
    le_s = -1; le_len = 0; errs_after = 0; rdy_err = 0; nin = 0; ndn = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (le_l[c] && le_s < 0) le_s = c;
      if (in_l[c]) nin++;
      if (dn_l[c]) ndn++;
    end
    if (le_s < 0) le_s = 0;
    for (int c = le_s; c < ncyc && le_l[c]; c++) le_len++;
    for (int c = le_s + 1 + D_W; c < ncyc; c++) begin
      if (!er_l[c] || le_l[c] || !bz_l[c]) errs_after++;
      if (rd_l[c]) rdy_err++;
    end
    chk("underrun.load_len", le_len, 1 + D_W);
    chk("underrun.err_before", er_l[le_s + D_W], 0);
    chk("underrun.err_at_boundary", er_l[le_s + 1 + D_W], 1);
    chk("underrun.load_off", le_l[le_s + 1 + D_W], 0);
    chk("underrun.err_sticky", errs_after, 0);
    chk("underrun.ready_low", rdy_err, 0);
    chk("underrun.no_init", nin, 0);
    chk("underrun.no_done", ndn, 0);
    chk("underrun.err_still", err, 1);
    reset_check("err_reset");

    // Sequencer must still work after recovering from ERR.
    set_basic();
    run_job(1'b0, 1'b0, 0, 120);
    check_job("post_err");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
